// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH clocks, start/done handshake.
// Each bit is formed by two cascaded half-subtractors feeding a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {borrow_out, difference} of x - y.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {(~x) & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_sub(x, y);
        h2 = half_sub(h1[0], bin);
        return {h1[1] | h2[1], h2[0]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] dsh_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             accept_s;
    logic             last_s;
    logic [1:0]       bit_s;

    // Handshake decode: start is honoured only outside RUN; last marks the final bit edge.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        bit_s    = full_sub(sa_r[0], sb_r[0], br_r);
        if ((state_r == IDLE) || (state_r == DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == RUN) && (cnt_r == LAST_CNT)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // State register with registered busy/done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the next state so the flags land in registers.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            RUN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand shift registers, running borrow, partial-result shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r  <= {WIDTH{1'b0}};
            sb_r  <= {WIDTH{1'b0}};
            dsh_r <= {WIDTH{1'b0}};
            br_r  <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            sa_r  <= a;
            sb_r  <= b;
            dsh_r <= {WIDTH{1'b0}};
            br_r  <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
            dsh_r <= {bit_s[0], dsh_r[WIDTH-1:1]};
            br_r  <= bit_s[1];
            cnt_r <= cnt_r + CW'(1);
        end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
            dsh_r <= dsh_r;
            br_r  <= br_r;
            cnt_r <= cnt_r;
        end
    end

    // Visible result: updated only on the final bit edge, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
        end else if (last_s) begin
            diff_r   <= {bit_s[0], dsh_r[WIDTH-1:1]};
            borrow_r <= bit_s[1];
        end else begin
            diff_r   <= diff_r;
            borrow_r <= borrow_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + randomized bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances).
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       busy8, done8, borrow8;
    logic       busy4, done4, borrow4;

    int errors = 0;
    int checks = 0;
    logic [7:0] prev_diff;
    logic       prev_borrow;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit interfere);
        int         cyc;
        logic [7:0] ed;
        logic       eb;
        ed = x - y;
        eb = (x < y);
        a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom()); b8 = 8'($urandom());
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 20) begin
            chk("busy8_run", busy8, 1'b1);
            chk("diff8_hold", {diff8, borrow8}, {prev_diff, prev_borrow});
            if (interfere && cyc == 2) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        chk("done8_latency", cyc, 9);
        chk("diff8", diff8, ed);
        chk("borrow8", borrow8, eb);
        chk("busy8_done", busy8, 1'b0);
        prev_diff = ed; prev_borrow = eb;
        @(negedge clk);
        chk("done8_pulse", done8, 1'b0);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        int cyc;
        a4 = x; b4 = y; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom()); b4 = 4'($urandom());
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 20) begin
            chk("busy4_run", busy4, 1'b1);
            @(negedge clk);
            cyc++;
        end
        chk("done4_latency", cyc, 5);
        chk("diff4", diff4, 4'((x - y) & 4'hF));
        chk("borrow4", borrow4, (x < y));
        @(negedge clk);
        chk("done4_pulse", done4, 1'b0);
    endtask

    logic [7:0] qa[0:27];
    logic [7:0] qb[0:27];
    int         ndone;

    initial begin
        rst = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
        prev_diff = 8'h00; prev_borrow = 1'b0;
        #1;
        chk("reset_out8", {busy8, done8, diff8, borrow8}, 11'h0);
        chk("reset_out4", {busy4, done4, diff4, borrow4}, 7'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op8(8'd5, 8'd3, 1'b0);
        op8(8'd3, 8'd5, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'hA5, 8'hA5, 1'b0);
        op8(8'hFF, 8'h00, 1'b0);
        op8(8'h80, 8'h01, 1'b1);

        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom()), 8'($urandom()), 1'b0);
        end
        op8(8'h80, 8'h01, 1'b0);

        // Asynchronous reset between edges, mid-operation.
        a8 = 8'($urandom()); b8 = 8'($urandom()); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy8_prereset", busy8, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst8", {busy8, done8, diff8, borrow8}, 11'h0);
        prev_diff = 8'h00; prev_borrow = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op8(8'd9, 8'd4, 1'b0);

        // start held high: captures at negedge indices 0, 9, 18; results at 9, 18, 27.
        ndone = 0;
        for (int n = 0; n <= 27; n++) begin
            if (n > 0) begin
                chk("b2b_done", done8, (n % 9 == 0));
                if (n % 9 == 0) begin
                    ndone++;
                    chk("b2b_diff", diff8, 8'(qa[n-9] - qb[n-9]));
                    chk("b2b_borrow", borrow8, (qa[n-9] < qb[n-9]));
                end
            end
            qa[n] = 8'($urandom()); qb[n] = 8'($urandom());
            a8 = qa[n]; b8 = qb[n];
            start8 = (n < 27);
            @(negedge clk);
        end
        chk("b2b_count", ndone, 3);
        start8 = 1'b0;
        chk("b2b_idle", {busy8, done8}, 2'b00);
        @(negedge clk);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op4(4'(x), 4'(y));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
